i2c_byte_master: RTL and testbench

- Single-byte I2C master, 400 kHz class, clocked from the 50 MHz system clock.
- Whenever the 8-bit input byte changes, and once after reset, it writes that byte to a fixed 7-bit slave address.
- It then reads one byte back from the same slave and presents it on the data output.
- Sits at the board top level; SCL and SDA are open-drain pads with external pull-ups.

---
 rtl/i2c_pkg.sv | 50 +++++
 rtl/i2c_qtr_tick.sv | 37 +++
 rtl/i2c_byte_master.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_pkg
// Function : Shared state, quarter-phase and R/W encodings for the I2C master
// Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_ADDR      = 4'd2,
        S_ADDR_ACK  = 4'd3,
        S_WDATA     = 4'd4,
        S_WDATA_ACK = 4'd5,
        S_STOP_W    = 4'd6,
        S_GAP       = 4'd7,
        S_RSTART    = 4'd8,
        S_RADDR     = 4'd9,
        S_RADDR_ACK = 4'd10,
        S_RDATA     = 4'd11,
        S_MNACK     = 4'd12,
        S_STOP_R    = 4'd13
    } state_e;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    // Quarter of the current SCL bit period
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } qtr_e;

    function automatic qtr_e qtr_next(input qtr_e q);
        qtr_e n;
        n = Q0;
        case (q)
            Q0:      n = Q1;
            Q1:      n = Q2;
            Q2:      n = Q3;
            default: n = Q0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_qtr_tick.sv
`default_nettype none
// ============================================================================
// Module   : i2c_qtr_tick
// Function : One-cycle pulse every QTR_CNT clocks while enabled
// Revision : 1.0  initial release
// ============================================================================
module i2c_qtr_tick #(
    parameter int QTR_CNT = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int c_cnt_w = (QTR_CNT > 1) ? $clog2(QTR_CNT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(QTR_CNT - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic               w_last;

    assign w_last = (cnt_q == c_cnt_last);
    assign tick_o = en_i && w_last;

    // Held at zero while disabled so the first quarter after enable is full length
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            cnt_q <= '0;
        end else if (w_last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : i2c_byte_master
// Function : Writes data_in to a fixed slave on change, then reads one byte back
// Revision : 1.0  initial release
// ============================================================================
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         QTR_CNT    = 32,
    parameter int         IDLE_QTRS  = 4
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    input  logic [7:0] data_in,
    output logic [7:0] data,
    inout  wire        SCL,
    inout  wire        SDA
);

    localparam int                 c_gap_w    = $clog2(IDLE_QTRS + 1);
    localparam logic [c_gap_w-1:0] c_gap_full = c_gap_w'(IDLE_QTRS);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(IDLE_QTRS - 1);

    state_e             state_q;
    qtr_e               qtr_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic [7:0]         rx_q;
    logic [7:0]         tx_byte_q;
    logic [7:0]         last_sent_q;
    logic [7:0]         data_q;
    logic               first_pending_q;
    logic               abort_q;
    logic               scl_oe_q;
    logic               sda_oe_q;
    logic               sda_meta_q;
    logic               sda_sync_q;
    logic [c_gap_w-1:0] gap_q;

    logic               w_tick;
    logic               w_tick_en;
    logic               w_gap_done;

    assign w_gap_done = (gap_q == c_gap_full);
    assign w_tick_en  = (state_q != S_IDLE) || !w_gap_done;

    i2c_qtr_tick #(
        .QTR_CNT (QTR_CNT)
    ) u_qtr_tick (
        .clk_i  (PCLK),
        .rst_ni (PRESETN),
        .en_i   (w_tick_en),
        .tick_o (w_tick)
    );

    assign SCL  = scl_oe_q ? 1'b0 : 1'bz;
    assign SDA  = sda_oe_q ? 1'b0 : 1'bz;
    assign data = data_q;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_q         <= S_IDLE;
            qtr_q           <= Q0;
            bit_q           <= 3'd0;
            shift_q         <= 8'h00;
            rx_q            <= 8'h00;
            tx_byte_q       <= 8'h00;
            last_sent_q     <= 8'h00;
            data_q          <= 8'h00;
            first_pending_q <= 1'b1;
            abort_q         <= 1'b0;
            scl_oe_q        <= 1'b0;
            sda_oe_q        <= 1'b0;
            sda_meta_q      <= 1'b1;
            sda_sync_q      <= 1'b1;
            gap_q           <= '0;
        end else begin
            sda_meta_q <= SDA;
            sda_sync_q <= sda_meta_q;

            case (state_q)
                S_IDLE: begin
                    if (w_tick && !w_gap_done) begin
                        gap_q <= gap_q + 1'b1;
                    end
                    if (w_gap_done && (first_pending_q || (data_in != last_sent_q))) begin
                        state_q         <= S_START;
                        qtr_q           <= Q0;
                        tx_byte_q       <= data_in;
                        last_sent_q     <= data_in;
                        first_pending_q <= 1'b0;
                        abort_q         <= 1'b0;
                    end
                end

                S_GAP: begin
                    if (w_tick) begin
                        gap_q <= gap_q + 1'b1;
                        if (gap_q == c_gap_last) begin
                            state_q <= S_RSTART;
                            qtr_q   <= Q0;
                        end
                    end
                end

                S_START, S_RSTART: begin
                    if (w_tick) begin
                        case (qtr_q)
                            Q0: begin
                                sda_oe_q <= 1'b1;
                                qtr_q    <= Q1;
                            end
                            Q1: begin
                                scl_oe_q <= 1'b1;
                                qtr_q    <= Q2;
                            end
                            default: begin
                                state_q  <= (state_q == S_START) ? S_ADDR : S_RADDR;
                                shift_q  <= {SLAVE_ADDR, (state_q == S_START) ? I2C_WR : I2C_RD};
                                sda_oe_q <= ~SLAVE_ADDR[6];
                                bit_q    <= 3'd0;
                                qtr_q    <= Q0;
                            end
                        endcase
                    end
                end

                S_STOP_W, S_STOP_R: begin
                    if (w_tick) begin
                        case (qtr_q)
                            Q0: qtr_q <= Q1;
                            Q1: begin
                                scl_oe_q <= 1'b0;
                                qtr_q    <= Q2;
                            end
                            default: begin
                                sda_oe_q <= 1'b0;
                                qtr_q    <= Q0;
                                gap_q    <= '0;
                                state_q  <= (state_q == S_STOP_W && !abort_q) ? S_GAP : S_IDLE;
                            end
                        endcase
                    end
                end

                default: begin
                    // Data and acknowledge bits share the same four-quarter clocking
                    if (w_tick) begin
                        qtr_q <= qtr_next(qtr_q);
                        if (qtr_q == Q1) begin
                            scl_oe_q <= 1'b0;
                        end
                        if (qtr_q == Q3) begin
                            scl_oe_q <= 1'b1;
                            case (state_q)
                                S_ADDR, S_WDATA, S_RADDR: begin
                                    bit_q   <= bit_q + 3'd1;
                                    shift_q <= {shift_q[6:0], 1'b0};
                                    if (bit_q == 3'd7) begin
                                        sda_oe_q <= 1'b0;
                                        state_q  <= (state_q == S_ADDR)  ? S_ADDR_ACK  :
                                                    (state_q == S_WDATA) ? S_WDATA_ACK : S_RADDR_ACK;
                                    end else begin
                                        sda_oe_q <= ~shift_q[6];
                                    end
                                end
                                S_ADDR_ACK: begin
                                    if (sda_sync_q) begin
                                        abort_q  <= 1'b1;
                                        sda_oe_q <= 1'b1;
                                        state_q  <= S_STOP_W;
                                    end else begin
                                        shift_q  <= tx_byte_q;
                                        sda_oe_q <= ~tx_byte_q[7];
                                        state_q  <= S_WDATA;
                                    end
                                end
                                S_WDATA_ACK: begin
                                    abort_q  <= sda_sync_q;
                                    sda_oe_q <= 1'b1;
                                    state_q  <= S_STOP_W;
                                end
                                S_RADDR_ACK: begin
                                    if (sda_sync_q) begin
                                        sda_oe_q <= 1'b1;
                                        state_q  <= S_STOP_R;
                                    end else begin
                                        sda_oe_q <= 1'b0;
                                        state_q  <= S_RDATA;
                                    end
                                end
                                S_RDATA: begin
                                    rx_q  <= {rx_q[6:0], sda_sync_q};
                                    bit_q <= bit_q + 3'd1;
                                    if (bit_q == 3'd7) begin
                                        state_q <= S_MNACK;
                                    end
                                    sda_oe_q <= 1'b0;
                                end
                                S_MNACK: begin
                                    data_q   <= rx_q;
                                    sda_oe_q <= 1'b1;
                                    state_q  <= S_STOP_R;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_byte_master
// Function : Randomized bench with a bus-level slave and transaction reference
// Revision : 1.0  initial release
// ============================================================================
module tb_i2c_byte_master;

    localparam int c_qtr  = 32;
    localparam int c_idle = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] data_in;
    logic [7:0] data;
    wire        scl_w;
    wire        sda_w;

    logic       slv_oe  = 1'b0;
    logic       present = 1'b1;
    logic [7:0] rd_val  = 8'hA5;

    pullup (scl_w);
    pullup (sda_w);
    assign sda_w = slv_oe ? 1'b0 : 1'bz;

    i2c_byte_master #(
        .SLAVE_ADDR (7'h50),
        .QTR_CNT    (c_qtr),
        .IDLE_QTRS  (c_idle)
    ) dut (
        .PCLK    (clk),
        .PRESETN (rstn),
        .data_in (data_in),
        .data    (data),
        .SCL     (scl_w),
        .SDA     (sda_w)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor and slave: decodes START/STOP, bytes, and plays an ACKing 0x50 device
    logic       p_scl = 1'b1, p_sda = 1'b1;
    logic       in_txn = 1'b0, rw = 1'b0, acked = 1'b0, mack = 1'b0;
    logic [7:0] sh = 8'h00, a_byte = 8'h00, w_byte = 8'h00;
    int         rises = 0, r0_cyc = 0, addr_period = 0, n_start = 0, prot_err = 0;
    logic [7:0] rec_addr[$];
    int         rec_rises[$];
    logic [7:0] rec_byte[$];
    logic       rec_mack[$];

    always @(negedge clk) begin
        logic s_c, s_d;
        int   pos, byt;
        s_c = scl_w;
        s_d = sda_w;
        pos = rises % 9;
        byt = rises / 9;
        if ($isunknown({s_c, s_d})) prot_err++;
        if (!rstn) begin
            in_txn = 1'b0;
            slv_oe = 1'b0;
        end else if (p_scl && s_c && p_sda && !s_d) begin
            if (in_txn) prot_err++;
            in_txn = 1'b1; rises = 0; acked = 1'b0; rw = 1'b0; mack = 1'b0;
            a_byte = 8'h00; w_byte = 8'h00; slv_oe = 1'b0;
            n_start++;
        end else if (p_scl && s_c && !p_sda && s_d) begin
            if (!in_txn || (rises % 9) != 1) prot_err++;
            rec_addr.push_back(a_byte);
            rec_rises.push_back(rises);
            rec_byte.push_back(w_byte);
            rec_mack.push_back(mack);
            in_txn = 1'b0;
            slv_oe = 1'b0;
        end else if (in_txn && !p_scl && s_c) begin
            if (rises == 0) r0_cyc = cyc;
            if (rises == 1) addr_period = cyc - r0_cyc;
            if (pos < 8) sh = {sh[6:0], s_d};
            if (pos == 7 && byt == 0) begin
                a_byte = sh;
                rw     = sh[0];
                acked  = present && (sh[7:1] == 7'h50);
            end else if (pos == 7 && byt == 1 && !rw) begin
                w_byte = sh;
            end
            if (pos == 8 && byt == 1 && rw) mack = s_d;
            rises++;
        end else if (in_txn && p_scl && !s_c) begin
            if (!acked)                 slv_oe = 1'b0;
            else if (pos == 8)          slv_oe = !(rw && byt >= 1);
            else if (rw && byt == 1)    slv_oe = !rd_val[7 - pos];
            else                        slv_oe = 1'b0;
        end
        p_scl = s_c;
        p_sda = s_d;
    end

    int         rd_idx = 0;
    logic [7:0] exp_data = 8'h00;

    task automatic wait_recs(input int n);
        int k;
        k = 0;
        while ((rec_addr.size() - rd_idx) < n && k < 9000) begin
            @(posedge clk);
            k++;
        end
        if ((rec_addr.size() - rd_idx) < n) chk("rec_timeout", rec_addr.size() - rd_idx, n);
    endtask

    task automatic wait_start(input int target);
        int k;
        k = 0;
        while (n_start < target && k < 6000) begin
            @(posedge clk);
            k++;
        end
        if (n_start < target) chk("start_timeout", n_start, target);
    endtask

    task automatic expect_pair(input logic [7:0] wb, input logic [7:0] rv);
        wait_recs(2);
        if ((rec_addr.size() - rd_idx) >= 2) begin
            chk("w_addr",  rec_addr[rd_idx],      8'hA0);
            chk("w_rises", rec_rises[rd_idx],     19);
            chk("w_byte",  rec_byte[rd_idx],      wb);
            chk("r_addr",  rec_addr[rd_idx + 1],  8'hA1);
            chk("r_rises", rec_rises[rd_idx + 1], 19);
            chk("r_mnack", rec_mack[rd_idx + 1],  1'b1);
            rd_idx += 2;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("data", data, rv);
        exp_data = rv;
        repeat ((c_idle + 2) * c_qtr) @(posedge clk);
    endtask

    initial begin
        logic [7:0] v, x;
        int         t0, st;

        rstn    = 1'b0;
        data_in = 8'h12;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data, 8'h00);
        chk("rst_scl", scl_w, 1'b1);
        chk("rst_sda", sda_w, 1'b1);
        @(negedge clk) rstn = 1'b1;

        // First transaction after reset carries the initial data_in
        wait_recs(1);
        #1;
        chk("mid_data", data, 8'h00);
        expect_pair(8'h12, 8'hA5);

        // Value changes while idle: quick START, correct byte and SCL period
        for (int i = 0; i < 3; i++) begin
            if (i == 0) v = 8'hD0;
            else begin
                do v = 8'($urandom_range(255)); while (v == data_in);
            end
            rd_val = 8'($urandom_range(255));
            st = n_start;
            @(negedge clk);
            data_in = v;
            t0 = cyc;
            wait_start(st + 1);
            chk("start_lat", 32'((cyc - t0) <= (c_qtr + c_idle * c_qtr)), 1);
            expect_pair(v, rd_val);
            chk("scl_period", addr_period, 4 * c_qtr);
        end

        // No slave: address NACK aborts the transaction, no retry
        present = 1'b0;
        do v = 8'($urandom_range(255)); while (v == data_in);
        @(negedge clk) data_in = v;
        wait_recs(1);
        if ((rec_addr.size() - rd_idx) >= 1) begin
            chk("nack_addr",  rec_addr[rd_idx],  8'hA0);
            chk("nack_rises", rec_rises[rd_idx], 10);
            rd_idx += 1;
        end
        st = n_start;
        repeat (40 * c_qtr) @(posedge clk);
        #1;
        chk("nack_data",  data, exp_data);
        chk("nack_quiet", n_start, st);
        present = 1'b1;

        // Changes during a transaction: only the final value is sent afterwards
        do x = 8'($urandom_range(255)); while (x == data_in || x == 8'h34 || x == 8'h56);
        rd_val = 8'($urandom_range(255));
        st = n_start;
        @(negedge clk) data_in = x;
        wait_start(st + 1);
        repeat (5 * c_qtr) @(posedge clk);
        @(negedge clk) data_in = 8'h34;
        repeat (200) @(posedge clk);
        @(negedge clk) data_in = 8'h56;
        expect_pair(x, rd_val);
        expect_pair(8'h56, rd_val);
        repeat (3000) @(posedge clk);
        chk("follow_once", n_start - st, 4);
        chk("follow_recs", rec_addr.size() - rd_idx, 0);

        // Reset mid-byte: lines released at once, data cleared, fresh transaction
        do x = 8'($urandom_range(255)); while (x == data_in);
        rd_val = 8'($urandom_range(255));
        st = n_start;
        @(negedge clk) data_in = x;
        wait_start(st + 1);
        begin
            int k;
            k = 0;
            while (rises < 4 && k < 3000) begin
                @(posedge clk);
                k++;
            end
        end
        @(negedge clk) rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_scl",  scl_w, 1'b1);
        chk("mid_rst_sda",  sda_w, 1'b1);
        chk("mid_rst_data", data, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        expect_pair(x, rd_val);

        chk("protocol", prot_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
